// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// The fetch buffer entry pairs an instruction word with its PC and misalignment tag.
package fetch_pkg;

  localparam int FETCH_ADDR_WIDTH = 32;
  localparam int FETCH_DATA_WIDTH = 32;
  localparam int FETCH_FIFO_DEPTH = 2;
  localparam int FETCH_CNT_WIDTH  = $clog2(FETCH_FIFO_DEPTH + 1);
  localparam int FETCH_PTR_WIDTH  = $clog2(FETCH_FIFO_DEPTH);

  localparam logic [FETCH_ADDR_WIDTH-1:0] FETCH_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [FETCH_ADDR_WIDTH-1:0] pc;
    logic [FETCH_DATA_WIDTH-1:0] instr;
    logic                        misaligned;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries between the SRAM capture and decode.
// Flush beats push and pop so a redirect leaves the buffer empty on the next cycle.
module fetch_fifo
  import fetch_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic                       i_flush,
  input  fetch_entry_t               i_entry,
  output fetch_entry_t               o_head,
  output logic [FETCH_CNT_WIDTH-1:0] o_count
);

  fetch_entry_t                 r_mem [FETCH_FIFO_DEPTH];
  logic [FETCH_PTR_WIDTH-1:0]   r_wr_ptr;
  logic [FETCH_PTR_WIDTH-1:0]   r_rd_ptr;
  logic [FETCH_CNT_WIDTH-1:0]   r_count;
  logic                         w_do_push;
  logic                         w_do_pop;

  assign w_do_push = i_push & (r_count != FETCH_CNT_WIDTH'(FETCH_FIFO_DEPTH));
  assign w_do_pop  = i_pop & (r_count != '0);

  // Storage is cleared on reset so the head reads as all-zero before the first push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FETCH_FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_entry;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count <= r_count + FETCH_CNT_WIDTH'(w_do_push) - FETCH_CNT_WIDTH'(w_do_pop);
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC sequencing, 1-cycle SRAM read capture, buffered handoff to decode.
// Optional FETCH_MISALIGN_CHECK_EN tags misaligned redirect targets and halts fetch until the next redirect.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH = FETCH_ADDR_WIDTH,
  parameter int                    DATA_WIDTH = FETCH_DATA_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = FETCH_RESET_PC
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] imem_addr_o,
  input  logic [DATA_WIDTH-1:0] imem_data_i,
  input  logic                  redirect_i,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
  output logic                  if_valid_o,
  input  logic                  if_ready_i,
  output logic [ADDR_WIDTH-1:0] if_pc_o,
  output logic [DATA_WIDTH-1:0] if_instr_o,
  output logic                  if_misaligned_o
);

  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);

  logic [ADDR_WIDTH-1:0]      r_pc;
  logic                       r_req_valid;
  logic [ADDR_WIDTH-1:0]      r_req_pc;
  logic                       r_req_mis;
  logic                       r_halt;

  logic [ADDR_WIDTH-1:0]      w_target;
  logic                       w_pop;
  logic                       w_push;
  logic                       w_issue;
  logic [FETCH_CNT_WIDTH-1:0] w_count;
  logic [FETCH_CNT_WIDTH:0]   w_occupancy;
  fetch_entry_t               w_push_entry;
  fetch_entry_t               w_head;

  assign w_target    = redirect_pc_i & ALIGN_MASK;
  assign imem_addr_o = redirect_i ? w_target : r_pc;

  assign if_valid_o = (w_count != '0) & ~redirect_i;
  assign w_pop      = if_valid_o & if_ready_i;

  // Credit check counts the read already in flight so its response always finds a free slot.
  assign w_occupancy = {1'b0, w_count} + (FETCH_CNT_WIDTH+1)'(r_req_valid)
                       - (FETCH_CNT_WIDTH+1)'(w_pop);
  assign w_issue     = redirect_i |
                       (~r_halt & (w_occupancy < (FETCH_CNT_WIDTH+1)'(FETCH_FIFO_DEPTH)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc        <= RESET_PC;
      r_req_valid <= 1'b0;
      r_req_pc    <= '0;
    end else begin
      r_req_valid <= w_issue;
      if (w_issue) begin
        r_req_pc <= imem_addr_o;
        r_pc     <= imem_addr_o + ADDR_WIDTH'(4);
      end
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  logic w_redirect_mis;

  assign w_redirect_mis = redirect_i & (|redirect_pc_i[1:0]);

  // A redirect always re-evaluates halt: cleared for aligned targets, set for misaligned ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_halt    <= 1'b0;
      r_req_mis <= 1'b0;
    end else begin
      r_req_mis <= w_issue & w_redirect_mis;
      if (redirect_i) begin
        r_halt <= w_redirect_mis;
      end
    end
  end
`else
  assign r_halt    = 1'b0;
  assign r_req_mis = 1'b0;
`endif

  // A redirect drops the response arriving this cycle along with everything buffered.
  assign w_push = r_req_valid & ~redirect_i;

  always_comb begin
    w_push_entry            = '0;
    w_push_entry.pc         = r_req_pc;
    w_push_entry.instr      = imem_data_i;
    w_push_entry.misaligned = r_req_mis;
  end

  fetch_fifo u_fetch_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (redirect_i),
    .i_entry (w_push_entry),
    .o_head  (w_head),
    .o_count (w_count)
  );

  assign if_pc_o         = w_head.pc;
  assign if_instr_o      = w_head.instr;
  assign if_misaligned_o = w_head.misaligned;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed self-checking bench for instruction_fetch with a 1-cycle-latency SRAM model.
// Memory word at byte address A holds 32'h1000_0000 + A/4.
module tb_instruction_fetch;

`ifdef FETCH_MISALIGN_CHECK_EN
  localparam logic MIS_EN = 1'b1;
`else
  localparam logic MIS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_data_i = '0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        if_valid_o;
  logic        if_ready_i = 1'b1;
  logic [31:0] if_pc_o;
  logic [31:0] if_instr_o;
  logic        if_misaligned_o;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_pc;

  instruction_fetch dut (
    .clk             (clk),
    .rst             (rst),
    .imem_addr_o     (imem_addr_o),
    .imem_data_i     (imem_data_i),
    .redirect_i      (redirect_i),
    .redirect_pc_i   (redirect_pc_i),
    .if_valid_o      (if_valid_o),
    .if_ready_i      (if_ready_i),
    .if_pc_o         (if_pc_o),
    .if_instr_o      (if_instr_o),
    .if_misaligned_o (if_misaligned_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) imem_data_i <= 32'h1000_0000 + (imem_addr_o >> 2);

  // Drive one cycle's inputs just after the falling edge, then let outputs settle.
  task automatic cycle(input logic rdy, input logic redir, input logic [31:0] tgt);
    @(negedge clk);
    if_ready_i    = rdy;
    redirect_i    = redir;
    redirect_pc_i = tgt;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (imem_addr_o !== 32'h0) begin failures++; $display("[TB] FAIL reset_addr got=%h exp=%h", imem_addr_o, 32'h0); end
    checks++; if (if_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%b exp=0", if_valid_o); end
    checks++; if (if_pc_o !== 32'h0) begin failures++; $display("[TB] FAIL reset_pc got=%h exp=0", if_pc_o); end
    checks++; if (if_instr_o !== 32'h0) begin failures++; $display("[TB] FAIL reset_instr got=%h exp=0", if_instr_o); end
    checks++; if (if_misaligned_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_mis got=%b exp=0", if_misaligned_o); end
  endtask

  task automatic test_stream();
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (imem_addr_o !== 32'h0) begin failures++; $display("[TB] FAIL stream_c0_addr got=%h exp=0", imem_addr_o); end
    checks++; if (if_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL stream_c0_valid got=%b exp=0", if_valid_o); end
    cycle(1'b1, 1'b0, 32'h0);
    checks++; if (imem_addr_o !== 32'h4) begin failures++; $display("[TB] FAIL stream_c1_addr got=%h exp=4", imem_addr_o); end
    checks++; if (if_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL stream_c1_valid got=%b exp=0", if_valid_o); end
    for (int c = 2; c < 8; c++) begin
      cycle(1'b1, 1'b0, 32'h0);
      checks++; if (if_valid_o !== 1'b1) begin failures++; $display("[TB] FAIL stream_valid c=%0d got=%b exp=1", c, if_valid_o); end
      checks++; if (if_pc_o !== 32'(4 * (c - 2))) begin failures++; $display("[TB] FAIL stream_pc c=%0d got=%h exp=%h", c, if_pc_o, 32'(4 * (c - 2))); end
      checks++; if (if_instr_o !== 32'h1000_0000 + 32'(c - 2)) begin failures++; $display("[TB] FAIL stream_instr c=%0d got=%h exp=%h", c, if_instr_o, 32'h1000_0000 + 32'(c - 2)); end
      checks++; if (imem_addr_o !== 32'(4 * c)) begin failures++; $display("[TB] FAIL stream_addr c=%0d got=%h exp=%h", c, imem_addr_o, 32'(4 * c)); end
    end
    exp_pc = 32'd24;
  endtask

  task automatic test_stall();
    for (int s = 0; s < 5; s++) begin
      cycle(1'b0, 1'b0, 32'h0);
      checks++; if (if_valid_o !== 1'b1) begin failures++; $display("[TB] FAIL stall_valid s=%0d got=%b exp=1", s, if_valid_o); end
      checks++; if (if_pc_o !== exp_pc) begin failures++; $display("[TB] FAIL stall_pc s=%0d got=%h exp=%h", s, if_pc_o, exp_pc); end
      checks++; if (if_instr_o !== 32'h1000_0000 + (exp_pc >> 2)) begin failures++; $display("[TB] FAIL stall_instr s=%0d got=%h exp=%h", s, if_instr_o, 32'h1000_0000 + (exp_pc >> 2)); end
      checks++; if (imem_addr_o !== exp_pc + 32'd8) begin failures++; $display("[TB] FAIL stall_addr s=%0d got=%h exp=%h", s, imem_addr_o, exp_pc + 32'd8); end
    end
    for (int r = 0; r < 6; r++) begin
      cycle(1'b1, 1'b0, 32'h0);
      checks++; if (if_valid_o !== 1'b1) begin failures++; $display("[TB] FAIL resume_valid r=%0d got=%b exp=1", r, if_valid_o); end
      checks++; if (if_pc_o !== exp_pc) begin failures++; $display("[TB] FAIL resume_pc r=%0d got=%h exp=%h", r, if_pc_o, exp_pc); end
      checks++; if (if_instr_o !== 32'h1000_0000 + (exp_pc >> 2)) begin failures++; $display("[TB] FAIL resume_instr r=%0d got=%h exp=%h", r, if_instr_o, 32'h1000_0000 + (exp_pc >> 2)); end
      checks++; if (imem_addr_o !== exp_pc + 32'd8) begin failures++; $display("[TB] FAIL resume_addr r=%0d got=%h exp=%h", r, imem_addr_o, exp_pc + 32'd8); end
      exp_pc = exp_pc + 32'd4;
    end
  endtask

  task automatic test_redirect_full();
    repeat (2) begin
      cycle(1'b0, 1'b0, 32'h0);
      checks++; if (if_pc_o !== exp_pc || if_valid_o !== 1'b1) begin failures++; $display("[TB] FAIL fill_head got=%b/%h exp=1/%h", if_valid_o, if_pc_o, exp_pc); end
    end
    cycle(1'b0, 1'b1, 32'h40);
    checks++; if (if_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL redir_full_valid got=%b exp=0", if_valid_o); end
    checks++; if (imem_addr_o !== 32'h40) begin failures++; $display("[TB] FAIL redir_full_addr got=%h exp=40", imem_addr_o); end
    cycle(1'b1, 1'b0, 32'h0);
    checks++; if (if_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL redir_full_gap got=%b exp=0", if_valid_o); end
    checks++; if (imem_addr_o !== 32'h44) begin failures++; $display("[TB] FAIL redir_full_addr2 got=%h exp=44", imem_addr_o); end
    cycle(1'b1, 1'b0, 32'h0);
    checks++; if (if_valid_o !== 1'b1 || if_pc_o !== 32'h40) begin failures++; $display("[TB] FAIL redir_full_entry got=%b/%h exp=1/40", if_valid_o, if_pc_o); end
    checks++; if (if_instr_o !== 32'h1000_0010) begin failures++; $display("[TB] FAIL redir_full_instr got=%h exp=10000010", if_instr_o); end
    checks++; if (imem_addr_o !== 32'h48) begin failures++; $display("[TB] FAIL redir_full_addr3 got=%h exp=48", imem_addr_o); end
    cycle(1'b1, 1'b0, 32'h0);
    checks++; if (if_valid_o !== 1'b1 || if_pc_o !== 32'h44) begin failures++; $display("[TB] FAIL redir_full_next got=%b/%h exp=1/44", if_valid_o, if_pc_o); end
  endtask

  task automatic test_redirect_pop();
    cycle(1'b1, 1'b0, 32'h0);
    checks++; if (if_valid_o !== 1'b1 || if_pc_o !== 32'h48) begin failures++; $display("[TB] FAIL pop_pre got=%b/%h exp=1/48", if_valid_o, if_pc_o); end
    cycle(1'b1, 1'b1, 32'h100);
    checks++; if (if_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL pop_redir_valid got=%b exp=0", if_valid_o); end
    checks++; if (imem_addr_o !== 32'h100) begin failures++; $display("[TB] FAIL pop_redir_addr got=%h exp=100", imem_addr_o); end
    cycle(1'b1, 1'b0, 32'h0);
    checks++; if (if_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL pop_redir_gap got=%b exp=0", if_valid_o); end
    cycle(1'b1, 1'b0, 32'h0);
    checks++; if (if_valid_o !== 1'b1 || if_pc_o !== 32'h100) begin failures++; $display("[TB] FAIL pop_redir_entry got=%b/%h exp=1/100", if_valid_o, if_pc_o); end
    checks++; if (if_instr_o !== 32'h1000_0040) begin failures++; $display("[TB] FAIL pop_redir_instr got=%h exp=10000040", if_instr_o); end
  endtask

  task automatic test_misaligned();
    cycle(1'b1, 1'b1, 32'h42);
    checks++; if (if_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL mis_redir_valid got=%b exp=0", if_valid_o); end
    checks++; if (imem_addr_o !== 32'h40) begin failures++; $display("[TB] FAIL mis_redir_addr got=%h exp=40", imem_addr_o); end
    cycle(1'b1, 1'b0, 32'h0);
    checks++; if (if_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL mis_gap got=%b exp=0", if_valid_o); end
    cycle(1'b1, 1'b0, 32'h0);
    checks++; if (if_valid_o !== 1'b1 || if_pc_o !== 32'h40) begin failures++; $display("[TB] FAIL mis_entry got=%b/%h exp=1/40", if_valid_o, if_pc_o); end
    checks++; if (if_instr_o !== 32'h1000_0010) begin failures++; $display("[TB] FAIL mis_instr got=%h exp=10000010", if_instr_o); end
    checks++; if (if_misaligned_o !== MIS_EN) begin failures++; $display("[TB] FAIL mis_flag got=%b exp=%b", if_misaligned_o, MIS_EN); end
    cycle(1'b1, 1'b0, 32'h0);
    checks++; if (if_valid_o !== ~MIS_EN) begin failures++; $display("[TB] FAIL mis_after_valid got=%b exp=%b", if_valid_o, ~MIS_EN); end
    if (!MIS_EN) begin
      checks++; if (if_pc_o !== 32'h44 || if_misaligned_o !== 1'b0) begin failures++; $display("[TB] FAIL mis_after_pc got=%h/%b exp=44/0", if_pc_o, if_misaligned_o); end
    end
    cycle(1'b1, 1'b0, 32'h0);
    checks++; if (if_valid_o !== ~MIS_EN) begin failures++; $display("[TB] FAIL mis_after2_valid got=%b exp=%b", if_valid_o, ~MIS_EN); end
    checks++; if (imem_addr_o !== (MIS_EN ? 32'h44 : 32'h50)) begin failures++; $display("[TB] FAIL mis_halt_addr got=%h exp=%h", imem_addr_o, (MIS_EN ? 32'h44 : 32'h50)); end
    cycle(1'b1, 1'b1, 32'h80);
    checks++; if (if_valid_o !== 1'b0 || imem_addr_o !== 32'h80) begin failures++; $display("[TB] FAIL mis_resume_redir got=%b/%h exp=0/80", if_valid_o, imem_addr_o); end
    cycle(1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 32'h0);
    checks++; if (if_valid_o !== 1'b1 || if_pc_o !== 32'h80) begin failures++; $display("[TB] FAIL mis_resume_entry got=%b/%h exp=1/80", if_valid_o, if_pc_o); end
    checks++; if (if_misaligned_o !== 1'b0 || if_instr_o !== 32'h1000_0020) begin failures++; $display("[TB] FAIL mis_resume_data got=%b/%h exp=0/10000020", if_misaligned_o, if_instr_o); end
    cycle(1'b1, 1'b0, 32'h0);
    checks++; if (if_valid_o !== 1'b1 || if_pc_o !== 32'h84) begin failures++; $display("[TB] FAIL mis_resume_next got=%b/%h exp=1/84", if_valid_o, if_pc_o); end
  endtask

  task automatic test_wrap();
    cycle(1'b1, 1'b1, 32'hFFFF_FFFC);
    checks++; if (imem_addr_o !== 32'hFFFF_FFFC) begin failures++; $display("[TB] FAIL wrap_addr0 got=%h exp=fffffffc", imem_addr_o); end
    cycle(1'b1, 1'b0, 32'h0);
    checks++; if (imem_addr_o !== 32'h0) begin failures++; $display("[TB] FAIL wrap_addr1 got=%h exp=0", imem_addr_o); end
    cycle(1'b1, 1'b0, 32'h0);
    checks++; if (if_valid_o !== 1'b1 || if_pc_o !== 32'hFFFF_FFFC) begin failures++; $display("[TB] FAIL wrap_entry got=%b/%h exp=1/fffffffc", if_valid_o, if_pc_o); end
    checks++; if (if_instr_o !== 32'h4FFF_FFFF) begin failures++; $display("[TB] FAIL wrap_instr got=%h exp=4fffffff", if_instr_o); end
    checks++; if (imem_addr_o !== 32'h4) begin failures++; $display("[TB] FAIL wrap_addr2 got=%h exp=4", imem_addr_o); end
    cycle(1'b1, 1'b0, 32'h0);
    checks++; if (if_pc_o !== 32'h0 || if_instr_o !== 32'h1000_0000) begin failures++; $display("[TB] FAIL wrap_next got=%h/%h exp=0/10000000", if_pc_o, if_instr_o); end
  endtask

  task automatic test_reset_mid();
    cycle(1'b1, 1'b0, 32'h0);
    checks++; if (if_valid_o !== 1'b1 || if_pc_o !== 32'h4) begin failures++; $display("[TB] FAIL rstmid_pre got=%b/%h exp=1/4", if_valid_o, if_pc_o); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (if_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_valid got=%b exp=0", if_valid_o); end
    checks++; if (imem_addr_o !== 32'h0 || if_pc_o !== 32'h0 || if_instr_o !== 32'h0) begin failures++; $display("[TB] FAIL rstmid_state got=%h/%h/%h exp=0/0/0", imem_addr_o, if_pc_o, if_instr_o); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (imem_addr_o !== 32'h0 || if_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_c0 got=%h/%b exp=0/0", imem_addr_o, if_valid_o); end
    cycle(1'b1, 1'b0, 32'h0);
    checks++; if (imem_addr_o !== 32'h4 || if_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_c1 got=%h/%b exp=4/0", imem_addr_o, if_valid_o); end
    cycle(1'b1, 1'b0, 32'h0);
    checks++; if (if_valid_o !== 1'b1 || if_pc_o !== 32'h0 || if_instr_o !== 32'h1000_0000) begin failures++; $display("[TB] FAIL rstmid_c2 got=%b/%h/%h exp=1/0/10000000", if_valid_o, if_pc_o, if_instr_o); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_full();
    test_redirect_pop();
    test_misaligned();
    test_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
